// File: rtl/antirebote_pkg.sv
// Shared definitions for the multichannel button debouncer: FSM encoding,
// default thresholds and a counter-width helper.
package antirebote_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } estado_t;

  localparam int unsigned DEF_COUNT_PRESS   = 50000;
  localparam int unsigned DEF_COUNT_RELEASE = 501;
  localparam int unsigned DEF_LONG_PRESS    = 1000000;

  // Bits needed to hold 0..v; at least one so a zero limit still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned v);
    int unsigned w;
    w = $clog2(v + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/antirebote_canal.sv
// One debounced button channel: 2-flop synchronizer, press/release FSM,
// debounce counter and saturating hold counter with registered pulses.
module antirebote_canal
  import antirebote_pkg::*;
#(
  parameter int unsigned COUNT_PRESS   = DEF_COUNT_PRESS,
  parameter int unsigned COUNT_RELEASE = DEF_COUNT_RELEASE,
  parameter int unsigned LONG_PRESS    = DEF_LONG_PRESS,
  parameter logic        ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_boton,
  output logic o_boton,
  output logic o_pulso_pres,
  output logic o_pulso_suelta,
  output logic o_pulso_largo
);

  localparam int unsigned CW = cnt_width((COUNT_PRESS > COUNT_RELEASE) ? COUNT_PRESS : COUNT_RELEASE);
  localparam int unsigned HW = cnt_width(LONG_PRESS);
  localparam logic [CW-1:0] CP_LAST = CW'(COUNT_PRESS - 1);
  localparam logic [CW-1:0] CR_LAST = CW'(COUNT_RELEASE - 1);
  localparam logic [HW-1:0] H_MAX   = HW'(LONG_PRESS);
  localparam logic [HW-1:0] H_LAST  = (LONG_PRESS > 0) ? HW'(LONG_PRESS - 1) : '0;
  localparam logic          LONG_EN = (LONG_PRESS > 0);

  logic          r_sync1, r_sync2;
  estado_t       r_estado, w_estado_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [HW-1:0] r_hold, w_hold_nx, w_hold_inc;
  logic          r_out, w_out_nx;
  logic          r_pres, w_pres_nx;
  logic          r_suelta, w_suelta_nx;
  logic          r_largo, w_largo_nx;
  logic          w_a, w_largo_hit;

  assign w_a         = r_sync2 ^ ACTIVE_LOW;
  assign w_hold_inc  = (r_hold != H_MAX) ? r_hold + HW'(1) : r_hold;
  // Saturation makes H_LAST reachable only once per press, so no auto-repeat.
  assign w_largo_hit = LONG_EN && (r_hold == H_LAST);

  always_comb begin
    w_estado_nx = r_estado;
    w_cnt_nx    = r_cnt;
    w_hold_nx   = r_hold;
    w_out_nx    = r_out;
    w_pres_nx   = 1'b0;
    w_suelta_nx = 1'b0;
    w_largo_nx  = 1'b0;
    case (r_estado)
      ST_IDLE: begin
        w_out_nx = 1'b0;
        if (w_a) begin
          w_estado_nx = ST_PRESS_WAIT;
          w_cnt_nx    = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!w_a) begin
          w_estado_nx = ST_IDLE;
          w_cnt_nx    = '0;
        end else if (r_cnt == CP_LAST) begin
          w_estado_nx = ST_PRESSED;
          w_hold_nx   = '0;
          w_out_nx    = 1'b1;
          w_pres_nx   = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      ST_PRESSED: begin
        if (!w_a) begin
          w_estado_nx = ST_RELEASE_WAIT;
          w_cnt_nx    = '0;
        end else begin
          w_hold_nx  = w_hold_inc;
          w_largo_nx = w_largo_hit;
        end
      end
      ST_RELEASE_WAIT: begin
        if (w_a) begin
          w_estado_nx = ST_PRESSED;
          w_hold_nx   = w_hold_inc;
          w_largo_nx  = w_largo_hit;
        end else if (r_cnt == CR_LAST) begin
          w_estado_nx = ST_IDLE;
          w_hold_nx   = '0;
          w_out_nx    = 1'b0;
          w_suelta_nx = 1'b1;
        end else begin
          w_cnt_nx   = r_cnt + CW'(1);
          w_hold_nx  = w_hold_inc;
          w_largo_nx = w_largo_hit;
        end
      end
      default: w_estado_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1  <= ACTIVE_LOW;
      r_sync2  <= ACTIVE_LOW;
      r_estado <= ST_IDLE;
      r_cnt    <= '0;
      r_hold   <= '0;
      r_out    <= 1'b0;
      r_pres   <= 1'b0;
      r_suelta <= 1'b0;
      r_largo  <= 1'b0;
    end else begin
      r_sync1  <= i_boton;
      r_sync2  <= r_sync1;
      r_estado <= w_estado_nx;
      r_cnt    <= w_cnt_nx;
      r_hold   <= w_hold_nx;
      r_out    <= w_out_nx;
      r_pres   <= w_pres_nx;
      r_suelta <= w_suelta_nx;
      r_largo  <= w_largo_nx;
    end
  end

  assign o_boton        = r_out;
  assign o_pulso_pres   = r_pres;
  assign o_pulso_suelta = r_suelta;
  assign o_pulso_largo  = r_largo;

endmodule

// File: rtl/antirebote_multicanal.sv
// Multichannel button debouncer: N_CH independent antirebote_canal instances,
// each given its own polarity bit.
module antirebote_multicanal
  import antirebote_pkg::*;
#(
  parameter int unsigned         N_CH          = 4,
  parameter int unsigned         COUNT_PRESS   = DEF_COUNT_PRESS,
  parameter int unsigned         COUNT_RELEASE = DEF_COUNT_RELEASE,
  parameter int unsigned         LONG_PRESS    = DEF_LONG_PRESS,
  parameter logic [N_CH-1:0]     ACTIVE_LOW    = {N_CH{1'b1}}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] boton_in,
  output logic [N_CH-1:0] boton_out,
  output logic [N_CH-1:0] pulso_pres,
  output logic [N_CH-1:0] pulso_suelta,
  output logic [N_CH-1:0] pulso_largo
);

  for (genvar g = 0; g < N_CH; g++) begin : g_canal
    antirebote_canal #(
      .COUNT_PRESS   (COUNT_PRESS),
      .COUNT_RELEASE (COUNT_RELEASE),
      .LONG_PRESS    (LONG_PRESS),
      .ACTIVE_LOW    (ACTIVE_LOW[g])
    ) u_canal (
      .clk            (clk),
      .reset          (reset),
      .i_boton        (boton_in[g]),
      .o_boton        (boton_out[g]),
      .o_pulso_pres   (pulso_pres[g]),
      .o_pulso_suelta (pulso_suelta[g]),
      .o_pulso_largo  (pulso_largo[g])
    );
  end

endmodule

// File: tb/tb_antirebote_multicanal.sv
// Bench for antirebote_multicanal: fixed vector table, directed corner-case
// sequences and a randomized run against a streak-counting reference model.
module tb_antirebote_multicanal;

  localparam int unsigned N_CH = 2;
  localparam int unsigned CP   = 4;
  localparam int unsigned CR   = 3;
  localparam int unsigned LP   = 10;
  localparam logic [1:0]  AL   = 2'b01;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] boton_in = AL;
  logic [1:0] boton_out, pulso_pres, pulso_suelta, pulso_largo;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  antirebote_multicanal #(
    .N_CH          (N_CH),
    .COUNT_PRESS   (CP),
    .COUNT_RELEASE (CR),
    .LONG_PRESS    (LP),
    .ACTIVE_LOW    (AL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .boton_in     (boton_in),
    .boton_out    (boton_out),
    .pulso_pres   (pulso_pres),
    .pulso_suelta (pulso_suelta),
    .pulso_largo  (pulso_largo)
  );

  // Reference model: debounced level flips after THR+1 consecutive opposing samples.
  logic m_s1 [2];
  logic m_s2 [2];
  int   m_lvl [2];
  int   m_streak [2];
  int   m_held [2];
  logic [1:0] e_out = '0, e_pres = '0, e_suelta = '0, e_largo = '0;

  task automatic model_edge(input logic rst, input logic [1:0] pins);
    logic a;
    int   thr;
    for (int ch = 0; ch < 2; ch++) begin
      e_pres[ch] = 1'b0; e_suelta[ch] = 1'b0; e_largo[ch] = 1'b0;
      if (!rst) begin
        m_s1[ch] = AL[ch]; m_s2[ch] = AL[ch];
        m_lvl[ch] = 0; m_streak[ch] = 0; m_held[ch] = 0;
      end else begin
        a = m_s2[ch] ^ AL[ch];
        m_s2[ch] = m_s1[ch];
        m_s1[ch] = pins[ch];
        if (int'(a) != m_lvl[ch]) m_streak[ch]++; else m_streak[ch] = 0;
        thr = (m_lvl[ch] != 0) ? CR : CP;
        if (m_streak[ch] == thr + 1) begin
          m_streak[ch] = 0;
          if (m_lvl[ch] == 0) begin
            m_lvl[ch] = 1; m_held[ch] = 0; e_pres[ch] = 1'b1;
          end else begin
            m_lvl[ch] = 0; e_suelta[ch] = 1'b1;
          end
        end else if (m_lvl[ch] != 0 && m_streak[ch] != 1) begin
          m_held[ch]++;
          if (LP > 0 && m_held[ch] == LP) e_largo[ch] = 1'b1;
        end
      end
      e_out[ch] = (m_lvl[ch] != 0);
    end
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic [1:0] pins);
    @(negedge clk);
    reset    = rst;
    boton_in = pins;
    @(posedge clk);
    model_edge(rst, pins);
    #1;
    chk("model_boton_out", boton_out, e_out);
    chk("model_pulso_pres", pulso_pres, e_pres);
    chk("model_pulso_suelta", pulso_suelta, e_suelta);
    chk("model_pulso_largo", pulso_largo, e_largo);
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] pins;
    logic [1:0] out, pres, suelta, largo;
  } vec_t;

  vec_t tbl [18];
  int   edge_n, t_pres, n_largo, n_suelta, lat;
  logic bad;

  initial begin
    // Ch0 press (1->0), then simultaneous ch0/ch1 press on the same edge.
    tbl[0] = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    for (int i = 1; i <= 6; i++) tbl[i] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[7] = '{1'b1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    tbl[8] = '{1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    tbl[9] = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    for (int i = 10; i <= 15; i++) tbl[i] = '{1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[16] = '{1'b1, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00};
    tbl[17] = '{1'b1, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst, tbl[i].pins);
      chk($sformatf("tbl%0d_boton_out", i), boton_out, tbl[i].out);
      chk($sformatf("tbl%0d_pulso_pres", i), pulso_pres, tbl[i].pres);
      chk($sformatf("tbl%0d_pulso_suelta", i), pulso_suelta, tbl[i].suelta);
      chk($sformatf("tbl%0d_pulso_largo", i), pulso_largo, tbl[i].largo);
    end

    // Short glitch: 3 cycles active then idle, nothing may move.
    step(1'b0, 2'b01);
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b00);
      if ((boton_out | pulso_pres | pulso_suelta | pulso_largo) != 2'b00) bad = 1'b1;
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 2'b01);
      if ((boton_out | pulso_pres | pulso_suelta | pulso_largo) != 2'b00) bad = 1'b1;
    end
    chk("glitch_no_output", {1'b0, bad}, 2'b00);

    // Release glitch then real release.
    step(1'b0, 2'b01);
    for (int i = 0; i < 7; i++) step(1'b1, 2'b00);
    chk("rel_pressed_first", boton_out, 2'b01);
    bad = 1'b0;
    n_suelta = 0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 2'b01);
      if (boton_out[0] !== 1'b1) bad = 1'b1;
      if (pulso_suelta[0]) n_suelta++;
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'b00);
      if (boton_out[0] !== 1'b1) bad = 1'b1;
      if (pulso_suelta[0]) n_suelta++;
    end
    chk("rel_glitch_level_kept", {1'b0, bad}, 2'b00);
    chk_int("rel_glitch_no_suelta", n_suelta, 0);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 2'b01);
      if (pulso_suelta[0]) n_suelta++;
      if (lat < 0 && boton_out[0] === 1'b0) begin
        lat = i;
        chk("rel_suelta_at_fall", pulso_suelta, 2'b01);
      end
    end
    chk_int("rel_fall_edge", lat, CR + 3);
    chk_int("rel_suelta_count", n_suelta, 1);

    // Long press: exactly one pulso_largo, LP cycles after pulso_pres.
    step(1'b0, 2'b01);
    t_pres = -1;
    for (int i = 1; i <= 20 && t_pres < 0; i++) begin
      step(1'b1, 2'b00);
      if (pulso_pres[0]) t_pres = i;
    end
    chk_int("long_pres_edge", t_pres, CP + 3);
    n_largo = 0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 2'b00);
      if (pulso_largo[0]) begin
        n_largo++;
        if (lat < 0) lat = i;
      end
    end
    chk_int("long_count", n_largo, 1);
    chk_int("long_latency", lat, LP);

    // Reset mid-press: all outputs cleared, no release pulse, re-debounce.
    step(1'b0, 2'b01);
    for (int i = 0; i < 7; i++) step(1'b1, 2'b00);
    chk("rst_pressed_before", boton_out, 2'b01);
    step(1'b0, 2'b00);
    chk("rst_boton_out", boton_out, 2'b00);
    chk("rst_pulses", pulso_pres | pulso_suelta | pulso_largo, 2'b00);
    lat = -1;
    n_suelta = 0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      step(1'b1, 2'b00);
      if (pulso_suelta[0]) n_suelta++;
      if (boton_out[0] === 1'b1) lat = i;
    end
    chk_int("rst_repress_edge", lat, CP + 3);
    chk_int("rst_no_suelta", n_suelta, 0);

    // Randomized run against the model.
    begin
      logic [1:0] pins;
      logic       rst;
      pins = AL;
      for (int i = 0; i < 3000; i++) begin
        for (int ch = 0; ch < 2; ch++)
          if ($urandom_range(5) == 0) pins[ch] = ~pins[ch];
        rst = ($urandom_range(299) != 0);
        step(rst, pins);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
